crb_rom_loader: RTL
===================

// Module: crb_rom_loader
// PURPOSE
//  Sits between hps_io's ioctl download stream and the CRAZYBALLOON core. Routes index-0 bytes
//  to the core's ROM write port with one registered cycle of latency. Captures the index-254
//  DIP bank and checks that the ROM image has the expected size.
//  Owns the core run/reset gate: the core is held in reset until a complete ROM has loaded.
// PARAMETERS
//  ROM_BYTES    16'h3800  exact ROM image size expected on ROM_INDEX (bytes)
//  ROM_INDEX    8'd0      ioctl_index carrying the ROM image
//  DIP_INDEX    8'd254    ioctl_index carrying DIP bytes
//  HOLD_CYCLES  16        CLK cycles core_reset stays high after a good ROM load ends
// PORTS
//  CLK            in   1   system clock (clk_sys domain)
//  RESET          in   1   synchronous, active-high; power-on/OSD reset only, never ioctl_download
//  ioctl_download in   1   download in progress
//  ioctl_wr       in   1   byte strobe, one CLK wide
//  ioctl_index    in   8   stream id, stable while ioctl_download=1
//  ioctl_addr     in   25  byte address
//  ioctl_dout     in   8   byte data
//  dn_addr        out  16  ROM write address to core
//  dn_data        out  8   ROM write data to core
//  dn_wr          out  1   ROM write strobe to core, one CLK wide
//  dn_ld          out  1   high while a ROM_INDEX download is active
//  dip            out  64  DIP bytes 0..7; byte n = dip[8n+7:8n]
//  core_reset     out  1   reset to core; OR'd with OSD reset at top level
//  rom_ok         out  1   last ROM load complete and in range
//  rom_err        out  1   sticky: last ROM load short, or address >= ROM_BYTES seen
// BEHAVIOUR
//  Reset values
//   - all outputs 0, except core_reset=1; dip=64'h0
//   - state IDLE, high-water counter hw=0
//  Index latch
//   - cur_idx <= ioctl_index on the rising edge of ioctl_download (edge from registered dl_q)
//   - ioctl_wr while ioctl_download=0 is ignored
//  FSM states: IDLE, LOAD_ROM, LOAD_DIP, HOLD, RUN
//   - IDLE/HOLD/RUN -> LOAD_ROM on rising edge with ioctl_index==ROM_INDEX:
//     clears hw, rom_ok and rom_err; core_reset=1; dn_ld=1
//   - IDLE/HOLD/RUN -> LOAD_DIP on rising edge with ioctl_index==DIP_INDEX:
//     core_reset is unchanged; the DIP value applies live
//   - any other index: stay in the current state; writes are ignored
//   - LOAD_ROM on falling edge of ioctl_download:
//     - dn_ld=0
//     - if hw==ROM_BYTES and no overflow: rom_ok=1, go to HOLD, load hold counter = HOLD_CYCLES
//     - otherwise: rom_err=1, go to IDLE, core_reset stays 1
//   - LOAD_DIP on falling edge: return to the state held before the DIP load (RUN or IDLE)
//   - HOLD: count down; at 0 go to RUN and drop core_reset on that same edge.
//     Exactly HOLD_CYCLES cycles of core_reset=1 after dn_ld falls.
//   - RUN: core_reset=0 until the next ROM download or RESET
//  ROM path (LOAD_ROM, ioctl_wr=1)
//   - addr < ROM_BYTES: next cycle dn_wr=1, dn_addr=addr[15:0], dn_data=dout;
//     hw <= max(hw, addr+1); hw is 17 bits
//   - addr >= ROM_BYTES: no dn_wr; rom_err <= 1 immediately
//   - duplicate or out-of-order addresses are legal; only hw is checked
//  DIP path (LOAD_DIP, ioctl_wr=1)
//   - only when addr[24:3]==0: dip byte addr[2:0] <= dout, visible the next cycle
//   - higher addresses are ignored silently
//  Simultaneous events
//   - ioctl_wr on the falling-edge cycle of ioctl_download is accepted and counted before the size check
//  RESET mid-operation
//   - RESET during a load aborts it: IDLE, dn_wr=0, dn_ld=0, core_reset=1, hw=0
//   - the remaining bytes of that download are ignored until the next rising edge
// STRUCTURE
//  Package crb_loader_pkg: state_t enum {IDLE,LOAD_ROM,LOAD_DIP,HOLD,RUN}; DIP_BYTES=8; HW_W=17.
//  Sub-module crb_dip_bank: 8x8 register file with write enable, byte select and flat 64-bit read.
//  FSM, ROM path and hold counter stay in crb_rom_loader.
// TESTING
//  1. RESET, ROM_INDEX load of 0x0000..0x37FF, ioctl_wr every 4th cycle
//     -> 14336 dn_wr pulses, each 1 cycle after ioctl_wr with matching addr/data
//     -> rom_ok=1; core_reset falls exactly 16 cycles after dn_ld falls
//  2. ROM load stops at 0x37FE -> rom_err=1, rom_ok=0, core_reset stays 1, state IDLE
//  3. ROM load including a write to 0x3800 -> no dn_wr for that byte; rom_err=1 at the next cycle
//  4. In RUN, DIP_INDEX load writing 0xA5 to addr 0 and 0x3C to addr 9
//     -> dip[7:0]=8'hA5, dip[63:8] unchanged, core_reset stays 0, return to RUN
//  5. RESET asserted mid ROM load at addr 0x1000 -> dn_ld=0, hw=0, core_reset=1
//     -> the following complete load succeeds
//  6. ioctl_wr pulses with ioctl_download=0, and a load on index 3
//     -> no dn_wr, dip and state unchanged

Source files
------------

// File: rtl/crb_loader_pkg.sv
// Shared types and sizes for the CRAZYBALLOON ROM/DIP loader.
// Imported by the loader top, DIP bank and testbench.
package crb_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ROM,
        LOAD_DIP,
        HOLD,
        RUN
    } state_t;

    localparam int DIP_BYTES = 8;
    localparam int HW_W      = 17;

endpackage

// File: rtl/crb_rom_loader_if.sv
// hps_io ioctl download stream as seen by the loader.
// master = hps_io side, slave = loader side.
interface crb_rom_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_index,
        output ioctl_addr,
        output ioctl_dout
    );

    modport slave (
        input ioctl_download,
        input ioctl_wr,
        input ioctl_index,
        input ioctl_addr,
        input ioctl_dout
    );

endinterface

// File: rtl/crb_dip_bank.sv
// Eight byte-wide DIP registers, byte-select write, flat 64-bit read.
// Byte n appears on q[8n+7:8n].
module crb_dip_bank
    import crb_loader_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         we,
    input  logic [$clog2(DIP_BYTES)-1:0] sel,
    input  logic [7:0]                   wdata,
    output logic [8*DIP_BYTES-1:0]       q
);

    logic [7:0] mem [DIP_BYTES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DIP_BYTES; i++)
                mem[i] <= 8'h00;
        end else if (we) begin
            mem[sel] <= wdata;
        end
    end

    for (genvar g = 0; g < DIP_BYTES; g++) begin : g_rd
        assign q[8*g +: 8] = mem[g];
    end

endmodule

// File: rtl/crb_rom_loader.sv
// ioctl -> CRAZYBALLOON ROM write port, DIP capture and core reset gate.
// The core stays in reset until a complete, in-range ROM image has loaded.
module crb_rom_loader
    import crb_loader_pkg::*;
#(
    parameter logic [15:0] ROM_BYTES   = 16'h3800,
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [7:0]  DIP_INDEX   = 8'd254,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    crb_rom_loader_if.slave      ioctl,
    output logic [15:0]          dn_addr,
    output logic [7:0]           dn_data,
    output logic                 dn_wr,
    output logic                 dn_ld,
    output logic [63:0]          dip,
    output logic                 core_reset,
    output logic                 rom_ok,
    output logic                 rom_err
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    state_t            state, state_n;
    state_t            ret_q, ret_n;
    logic [HW_W-1:0]   hw, hw_n;
    logic [HC_W-1:0]   cnt, cnt_n;
    logic              ok_n, err_n, crst_n;
    logic              dl_q, rise, fall;
    logic              wr_acc, in_rng;
    logic              rom_wr, rom_bad, dip_we;
    logic [HW_W-1:0]   addr_p1;

    assign rise = ioctl.ioctl_download & ~dl_q;
    assign fall = ~ioctl.ioctl_download & dl_q;

    // A strobe coincident with the falling edge still belongs to the load.
    assign wr_acc  = ioctl.ioctl_wr & (ioctl.ioctl_download | dl_q);
    assign in_rng  = ioctl.ioctl_addr < {9'd0, ROM_BYTES};
    assign addr_p1 = {1'b0, ioctl.ioctl_addr[15:0]} + 17'd1;

    assign rom_wr  = (state == LOAD_ROM) & wr_acc & in_rng;
    assign rom_bad = (state == LOAD_ROM) & wr_acc & ~in_rng;
    assign dip_we  = (state == LOAD_DIP) & wr_acc
                   & (ioctl.ioctl_addr[24:3] == 22'd0);

    assign dn_ld = (state == LOAD_ROM);

    always_comb begin
        state_n = state;
        ret_n   = ret_q;
        hw_n    = hw;
        cnt_n   = cnt;
        ok_n    = rom_ok;
        err_n   = rom_err;
        crst_n  = core_reset;
        if (rom_wr && addr_p1 > hw)
            hw_n = addr_p1;
        if (rom_bad)
            err_n = 1'b1;
        unique case (state)
            IDLE, HOLD, RUN: begin
                if (state == HOLD) begin
                    if (cnt == HC_W'(1)) begin
                        state_n = RUN;
                        crst_n  = 1'b0;
                    end else begin
                        cnt_n = cnt - HC_W'(1);
                    end
                end
                if (rise && ioctl.ioctl_index == ROM_INDEX) begin
                    state_n = LOAD_ROM;
                    hw_n    = '0;
                    ok_n    = 1'b0;
                    err_n   = 1'b0;
                    crst_n  = 1'b1;
                end else if (rise && ioctl.ioctl_index == DIP_INDEX) begin
                    ret_n   = state_n;
                    state_n = LOAD_DIP;
                end
            end
            LOAD_ROM: begin
                if (fall) begin
                    if (hw_n == {1'b0, ROM_BYTES} && !err_n) begin
                        ok_n    = 1'b1;
                        state_n = HOLD;
                        cnt_n   = HC_W'(HOLD_CYCLES);
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            LOAD_DIP: begin
                if (fall)
                    state_n = ret_q;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            ret_q      <= IDLE;
            hw         <= '0;
            cnt        <= '0;
            rom_ok     <= 1'b0;
            rom_err    <= 1'b0;
            core_reset <= 1'b1;
            // No false rising edge if RESET lands mid-download.
            dl_q       <= ioctl.ioctl_download;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
        end else begin
            state      <= state_n;
            ret_q      <= ret_n;
            hw         <= hw_n;
            cnt        <= cnt_n;
            rom_ok     <= ok_n;
            rom_err    <= err_n;
            core_reset <= crst_n;
            dl_q       <= ioctl.ioctl_download;
            dn_wr      <= rom_wr;
            if (rom_wr) begin
                dn_addr <= ioctl.ioctl_addr[15:0];
                dn_data <= ioctl.ioctl_dout;
            end
        end
    end

    crb_dip_bank u_dip (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (dip_we),
        .sel   (ioctl.ioctl_addr[2:0]),
        .wdata (ioctl.ioctl_dout),
        .q     (dip)
    );

endmodule
